// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 byte stream to key-event decoder with a small FWFT event FIFO.
// Prefix bytes (E0, F0, E1 sequences) are folded into ext/release flags on each event.
module ps2_scancode_decoder #(
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scan_valid,
  input  logic [7:0]        scan_data,
  input  logic              rd_en,
  input  logic              clr_overflow,
  output logic [7:0]        key_code,
  output logic              key_ext,
  output logic              key_release,
  output logic              key_valid,
  output logic [ADDR_W:0]   fifo_count,
  output logic              overflow,
  output logic              irq
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK,
    SKIP
  } state_t;

  state_t            state;
  logic [2:0]        skip_cnt;
  logic              scan_valid_q;
  logic              byte_ev;

  logic              push;
  logic              push_ext;
  logic              push_rel;
  logic [7:0]        push_code;

  logic [9:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              full;
  logic              do_rd;
  logic              do_wr;

  // Edge register resets high so a tick already asserted at reset release is ignored
  always_ff @(posedge clk or posedge reset) begin
    if (reset) scan_valid_q <= 1'b1;
    else       scan_valid_q <= scan_valid;
  end

  assign byte_ev = scan_valid & ~scan_valid_q;

  always_comb begin
    push      = 1'b0;
    push_ext  = 1'b0;
    push_rel  = 1'b0;
    push_code = scan_data;
    if (byte_ev) begin
      unique case (state)
        IDLE: begin
          unique case (scan_data)
            8'hE0, 8'hF0, 8'hE1,
            8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: push = 1'b0;
            default: push = 1'b1;
          endcase
        end
        EXT: begin
          push     = (scan_data != 8'hF0) && (scan_data != 8'hE0) && (scan_data != 8'h12);
          push_ext = 1'b1;
        end
        BRK: begin
          push     = 1'b1;
          push_rel = 1'b1;
        end
        EXT_BRK: begin
          push     = (scan_data != 8'h12);
          push_ext = 1'b1;
          push_rel = 1'b1;
        end
        SKIP: begin
          // The whole Pause sequence collapses into a single E1 event
          push      = (skip_cnt == 3'd1);
          push_ext  = 1'b1;
          push_code = 8'hE1;
        end
        default: push = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      skip_cnt <= 3'd0;
    end else if (byte_ev) begin
      unique case (state)
        IDLE: begin
          if (scan_data == 8'hE0)      state <= EXT;
          else if (scan_data == 8'hF0) state <= BRK;
          else if (scan_data == 8'hE1) begin
            state    <= SKIP;
            skip_cnt <= 3'd7;
          end
        end
        EXT: begin
          if (scan_data == 8'hF0)      state <= EXT_BRK;
          else if (scan_data != 8'hE0) state <= IDLE;
        end
        BRK:     state <= IDLE;
        EXT_BRK: state <= IDLE;
        SKIP: begin
          skip_cnt <= skip_cnt - 3'd1;
          if (skip_cnt == 3'd1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A full FIFO still accepts a write when the head is popped in the same cycle
  assign full      = (fifo_count == (ADDR_W+1)'(DEPTH));
  assign key_valid = (fifo_count != '0);
  assign do_rd     = rd_en & key_valid;
  assign do_wr     = push & (~full | do_rd);

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= {push_code, push_ext, push_rel};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      irq        <= 1'b0;
    end else begin
      irq <= do_wr;
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      if (do_wr && !do_rd)      fifo_count <= fifo_count + 1'b1;
      else if (do_rd && !do_wr) fifo_count <= fifo_count - 1'b1;
      if (push && !do_wr)    overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

  assign key_code    = key_valid ? mem[rd_ptr][9:2] : 8'h00;
  assign key_ext     = key_valid ? mem[rd_ptr][1]   : 1'b0;
  assign key_release = key_valid ? mem[rd_ptr][0]   : 1'b0;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder; inputs driven and outputs sampled on the falling edge.
module tb_ps2_scancode_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       scan_valid;
  logic [7:0] scan_data;
  logic       rd_en;
  logic       clr_overflow;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_release;
  logic       key_valid;
  logic [3:0] fifo_count;
  logic       overflow;
  logic       irq;

  int tests_run = 0;
  int tests_failed = 0;
  int irq_count = 0;

  ps2_scancode_decoder #(.ADDR_W(3)) dut (
    .clk(clk), .reset(reset), .scan_valid(scan_valid), .scan_data(scan_data),
    .rd_en(rd_en), .clr_overflow(clr_overflow), .key_code(key_code),
    .key_ext(key_ext), .key_release(key_release), .key_valid(key_valid),
    .fifo_count(fifo_count), .overflow(overflow), .irq(irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (irq) irq_count++;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clean byte: tick high for two cycles, then low for two
  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clk);
    scan_valid = 1'b1;
    scan_data  = b;
    @(negedge clk);
    @(negedge clk);
    scan_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic popCheck(input string tag, input logic [9:0] exp);
    @(negedge clk);
    checkOutput(tag, {21'd0, key_valid, key_code, key_ext, key_release}, {21'd0, 1'b1, exp});
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  logic [7:0] seq_pre [7]  = '{8'hF0, 8'h1C, 8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75};
  logic [7:0] seq_pau [12] = '{8'hFA, 8'hAA, 8'hE0, 8'h12, 8'hE1, 8'h14, 8'h77,
                               8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

  initial begin
    reset = 1'b1; scan_valid = 1'b0; scan_data = 8'h00; rd_en = 1'b0; clr_overflow = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset key_valid", key_valid, 0);
    checkOutput("reset fifo_count", fifo_count, 0);
    checkOutput("reset overflow", overflow, 0);
    checkOutput("reset irq", irq, 0);
    checkOutput("reset key_code", {key_code, key_ext, key_release}, 0);

    // Held strobe
    irq_count = 0;
    scan_valid = 1'b1; scan_data = 8'h1C;
    @(negedge clk);
    checkOutput("held irq first", irq, 1);
    checkOutput("held count", fifo_count, 1);
    @(negedge clk);
    checkOutput("held irq second", irq, 0);
    repeat (23) @(negedge clk);
    scan_valid = 1'b0;
    @(negedge clk);
    checkOutput("held irq total", irq_count, 1);
    checkOutput("held count end", fifo_count, 1);
    popCheck("held event", {8'h1C, 2'b00});

    // Prefixes
    irq_count = 0;
    for (int i = 0; i < 7; i++) applyStimulus(seq_pre[i]);
    checkOutput("prefix irqs", irq_count, 3);
    popCheck("prefix brk", {8'h75 ^ 8'h69, 2'b01});
    popCheck("prefix ext", {8'h75, 2'b10});
    popCheck("prefix ext_brk", {8'h75, 2'b11});

    // Discards and Pause
    irq_count = 0;
    for (int i = 0; i < 12; i++) applyStimulus(seq_pau[i]);
    checkOutput("pause count", fifo_count, 1);
    checkOutput("pause irqs", irq_count, 1);
    popCheck("pause event", {8'hE1, 2'b10});
    applyStimulus(8'h1C);
    popCheck("pause idle after", {8'h1C, 2'b00});
    checkOutput("pause drained", fifo_count, 0);

    // Full FIFO
    irq_count = 0;
    for (int i = 0; i < 9; i++) applyStimulus(8'h10 + 8'(i));
    checkOutput("full count", fifo_count, 8);
    checkOutput("full overflow", overflow, 1);
    checkOutput("full irqs", irq_count, 8);
    checkOutput("full head", key_code, 8'h10);
    @(negedge clk); clr_overflow = 1'b1;
    @(negedge clk); clr_overflow = 1'b0;
    checkOutput("clr overflow", overflow, 0);

    // Simultaneous push and pop while full
    @(negedge clk);
    scan_valid = 1'b1; scan_data = 8'h2A; rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    checkOutput("simul count", fifo_count, 8);
    checkOutput("simul irq", irq, 1);
    checkOutput("simul overflow", overflow, 0);
    checkOutput("simul head", key_code, 8'h11);
    @(negedge clk); scan_valid = 1'b0;
    @(negedge clk);
    for (int i = 1; i < 8; i++) popCheck("drain", {8'h10 + 8'(i), 2'b00});
    popCheck("drain last", {8'h2A, 2'b00});
    @(negedge clk); rd_en = 1'b1;
    @(negedge clk); rd_en = 1'b0;
    checkOutput("empty rd count", fifo_count, 0);
    checkOutput("empty rd valid", key_valid, 0);
    applyStimulus(8'h33);
    popCheck("after empty rd", {8'h33, 2'b00});

    // Reset mid-sequence with the tick still high
    @(negedge clk); scan_valid = 1'b1; scan_data = 8'hE0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    @(negedge clk); @(negedge clk);
    checkOutput("rst mid count", fifo_count, 0);
    scan_valid = 1'b0;
    @(negedge clk);
    applyStimulus(8'h1C);
    checkOutput("rst mid count2", fifo_count, 1);
    popCheck("rst mid event", {8'h1C, 2'b00});

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
